// File: rtl/aes_ctrl_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | aes_ctrl_pkg : shared types and constants for the AES decrypt        |
// |                scheduler (FSM states, block/counter widths, LAT).    |
// | Revision     : 1.0                                                   |
// +----------------------------------------------------------------------+
package aes_ctrl_pkg;

  localparam int LAT_DEFAULT = 20;
  localparam int BLK_W       = 128;
  localparam int CNT_W       = 5;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_e;

endpackage
`default_nettype wire

// File: rtl/aes_dec_scheduler_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | aes_dec_scheduler_if : requester, core and response channel bundle.  |
// |                        slave = scheduler view, master = environment. |
// | Revision             : 1.0                                           |
// +----------------------------------------------------------------------+
interface aes_dec_scheduler_if;
  import aes_ctrl_pkg::*;

  logic             s0_valid;
  logic             s0_ready;
  logic [BLK_W-1:0] s0_data;
  logic [BLK_W-1:0] s0_key;
  logic             s1_valid;
  logic             s1_ready;
  logic [BLK_W-1:0] s1_data;
  logic [BLK_W-1:0] s1_key;
  logic [BLK_W-1:0] core_data_in;
  logic [BLK_W-1:0] core_key;
  logic [BLK_W-1:0] core_data_out;
  logic             m_valid;
  logic             m_ready;
  logic [BLK_W-1:0] m_data;
  logic             m_id;
  logic             busy;

  modport slave (
    input  s0_valid, s0_data, s0_key, s1_valid, s1_data, s1_key,
    input  core_data_out, m_ready,
    output s0_ready, s1_ready, core_data_in, core_key,
    output m_valid, m_data, m_id, busy
  );

  modport master (
    output s0_valid, s0_data, s0_key, s1_valid, s1_data, s1_key,
    output core_data_out, m_ready,
    input  s0_ready, s1_ready, core_data_in, core_key,
    input  m_valid, m_data, m_id, busy
  );

endinterface
`default_nettype wire

// File: rtl/aes_dec_scheduler_arb.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | rr_arb2  : two-requester arbiter. RR_ARB_EN selects round-robin,     |
// |            otherwise requester 0 has fixed priority.                 |
// | Revision : 1.0                                                       |
// +----------------------------------------------------------------------+
module rr_arb2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req_i,
  input  logic       accept_i,
  output logic [1:0] grant_o
);

`ifdef RR_ARB_EN
  // Resets to 1 so the first contended grant goes to requester 0.
  logic last_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      last_q <= 1'b1;
    end else if (accept_i) begin
      last_q <= grant_o[1];
    end
  end

  always_comb begin
    grant_o = req_i;
    if (req_i == 2'b11) begin
      grant_o = last_q ? 2'b01 : 2'b10;
    end
  end
`else
  logic w_unused;
  assign w_unused = ^{clk, rst, accept_i};

  assign grant_o = req_i[0] ? 2'b01 : {req_i[1], 1'b0};
`endif

endmodule
`default_nettype wire

// File: rtl/aes_dec_scheduler.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | aes_dec_scheduler : shares one AES decrypt core between two          |
// |                     requesters; arbitration mode set by RR_ARB_EN.   |
// | Revision          : 1.0                                              |
// +----------------------------------------------------------------------+
module aes_dec_scheduler
  import aes_ctrl_pkg::*;
#(
  parameter int LAT = LAT_DEFAULT
) (
  input  logic               clk,
  input  logic               rst,
  aes_dec_scheduler_if.slave sched_io
);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             m_valid_q, m_valid_d;
  logic             m_id_q, m_id_d;
  logic [BLK_W-1:0] m_data_q, m_data_d;
  logic [BLK_W-1:0] core_data_q, core_data_d;
  logic [BLK_W-1:0] core_key_q, core_key_d;

  logic [1:0]       w_req;
  logic [1:0]       w_grant;
  logic             w_accept;

  // Requests are only visible in IDLE and never during reset, so ready stays low otherwise.
  assign w_req    = (state_q == ST_IDLE && !rst) ? {sched_io.s1_valid, sched_io.s0_valid} : 2'b00;
  assign w_accept = |w_grant;

  rr_arb2 u_arb (
    .clk      (clk),
    .rst      (rst),
    .req_i    (w_req),
    .accept_i (w_accept),
    .grant_o  (w_grant)
  );

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    m_valid_d   = m_valid_q;
    m_id_d      = m_id_q;
    m_data_d    = m_data_q;
    core_data_d = core_data_q;
    core_key_d  = core_key_q;
    case (state_q)
      ST_IDLE: begin
        if (w_accept) begin
          core_data_d = w_grant[1] ? sched_io.s1_data : sched_io.s0_data;
          core_key_d  = w_grant[1] ? sched_io.s1_key  : sched_io.s0_key;
          m_id_d      = w_grant[1];
          cnt_d       = CNT_W'(LAT - 1);
          state_d     = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (cnt_q == '0) begin
          m_data_d  = sched_io.core_data_out;
          m_valid_d = 1'b1;
          state_d   = ST_RESP;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_RESP: begin
        if (sched_io.m_ready) begin
          m_valid_d = 1'b0;
          state_d   = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      m_valid_q   <= 1'b0;
      m_id_q      <= 1'b0;
      m_data_q    <= '0;
      core_data_q <= '0;
      core_key_q  <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      m_valid_q   <= m_valid_d;
      m_id_q      <= m_id_d;
      m_data_q    <= m_data_d;
      core_data_q <= core_data_d;
      core_key_q  <= core_key_d;
    end
  end

  assign sched_io.s0_ready     = w_grant[0];
  assign sched_io.s1_ready     = w_grant[1];
  assign sched_io.core_data_in = core_data_q;
  assign sched_io.core_key     = core_key_q;
  assign sched_io.m_valid      = m_valid_q;
  assign sched_io.m_data       = m_data_q;
  assign sched_io.m_id         = m_id_q;
  assign sched_io.busy         = (state_q != ST_IDLE);

endmodule
`default_nettype wire
